// File: rtl/board_move_collector.sv
// -----------------------------------------------------------------------------
// board_move_collector
//
// Board-level scheduler for the column array. A start pulse sends a one-cycle
// reset to every column, then the per-column move FIFOs are drained round-robin
// into a single valid/ready move stream. Accepted moves are counted
// (saturating), and the pass ends either when every column is done and empty
// or when no word has been read for TMO_CYC scan cycles (sticky timeout).
//
// Ports
//   clk         in   1         rising-edge clock
//   reset       in   1         synchronous, active-high
//   start       in   1         begins a pass; honoured only in IDLE or DONE
//   col_reset   out  1         one-cycle reset pulse to all columns
//   col_done    in   NCOL      per-column done
//   col_empty   in   NCOL      per-column FIFO empty
//   col_data    in   NCOL*DW   column i word on [i*DW +: DW], valid the cycle after rden
//   col_rden    out  NCOL      per-column FIFO read enable (one-hot or zero)
//   move_data   out  DW        output move word
//   move_valid  out  1         move_data valid
//   move_ready  in   1         consumer accepts when move_valid & move_ready
//   busy        out  1         high in RST, SCAN, DRAIN
//   all_done    out  1         high in DONE
//   timeout     out  1         sticky timeout flag, cleared by start or reset
//   move_count  out  CNTW      moves accepted this pass, saturating
// -----------------------------------------------------------------------------
module board_move_collector #(
   parameter int NCOL    = 8,
   parameter int DW      = 160,
   parameter int CNTW    = 8,
   parameter int TMO_CYC = 4095
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 col_reset,
   input  logic [NCOL-1:0]      col_done,
   input  logic [NCOL-1:0]      col_empty,
   input  logic [NCOL*DW-1:0]   col_data,
   output logic [NCOL-1:0]      col_rden,
   output logic [DW-1:0]        move_data,
   output logic                 move_valid,
   input  logic                 move_ready,
   output logic                 busy,
   output logic                 all_done,
   output logic                 timeout,
   output logic [CNTW-1:0]      move_count
);

   localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int TW = $clog2(TMO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [PW-1:0]     r_sel;
   logic [PW-1:0]     r_rr_ptr;
   logic [TW-1:0]     r_tmo_cnt;
   logic              r_timeout;
   logic [DW-1:0]     r_move_data;
   logic              r_move_valid;
   logic [CNTW-1:0]   r_move_count;

   logic [NCOL-1:0]   w_elig;
   logic              w_slot_free;
   logic              w_xfer;
   logic              w_found;
   logic [PW-1:0]     w_pick;
   logic              w_complete;
   logic              w_read;
   logic              w_tmo_hit;
   logic              w_start_ok;

   // (base + off) mod NCOL, with base < NCOL and off < NCOL.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      logic [PW:0] s;
      s = {1'b0, base} + (PW+1)'(off);
      if (s >= (PW+1)'(NCOL)) s = s - (PW+1)'(NCOL);
      return s[PW-1:0];
   endfunction

   // ---------------------------------------------------------------------------
   // Shared decode
   // ---------------------------------------------------------------------------
   assign w_elig      = col_done & ~col_empty;
   assign w_xfer      = r_move_valid & move_ready;
   // The output register can take a new word if it is empty or drains this cycle.
   assign w_slot_free = ~r_move_valid | move_ready;
   assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_complete  = (r_state == S_SCAN) & (&col_done) & (&col_empty) & ~r_move_valid;
   assign w_read      = (r_state == S_SCAN) & ~w_complete & w_slot_free & w_found;
   assign w_tmo_hit   = (r_tmo_cnt == TW'(TMO_CYC - 1));

   // Round-robin pick: first eligible column at or after rr_ptr. rr_ptr holds
   // the last column served, so that column keeps priority while it still has
   // words; once it runs dry the search naturally continues at rr_ptr+1.
   // NOTE: every always_comb output gets a default before any branch so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NCOL; k++) begin
         if (!w_found && w_elig[wrap_add(r_rr_ptr, k)]) begin
            w_found = 1'b1;
            w_pick  = wrap_add(r_rr_ptr, k);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RST;
         S_RST:   w_state_nxt = S_SCAN;
         S_SCAN: begin
            // Completion wins over a timeout landing in the same cycle.
            if (w_complete)     w_state_nxt = S_DONE;
            else if (w_read)    w_state_nxt = S_DRAIN;
            else if (w_tmo_hit) w_state_nxt = S_DONE;
         end
         // The column's empty flag lags rden by a cycle, so DRAIN never reads.
         S_DRAIN: w_state_nxt = S_SCAN;
         S_DONE:  if (start) w_state_nxt = S_RST;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      col_reset = (r_state == S_RST);
      busy      = (r_state == S_RST) | (r_state == S_SCAN) | (r_state == S_DRAIN);
      all_done  = (r_state == S_DONE);
      col_rden  = w_read ? (NCOL'(1) << w_pick) : '0;
   end

   // ---------------------------------------------------------------------------
   // Datapath: selection, output register, counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel        <= '0;
         r_rr_ptr     <= '0;
         r_tmo_cnt    <= '0;
         r_timeout    <= 1'b0;
         r_move_data  <= '0;
         r_move_valid <= 1'b0;
         r_move_count <= '0;
      end else begin
         if (w_read) r_sel <= w_pick;

         // Idle-scan counter restarts on each read and on entry to SCAN.
         if (r_state == S_RST || w_read)  r_tmo_cnt <= '0;
         else if (r_state == S_SCAN)      r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if (w_start_ok)
            r_timeout <= 1'b0;
         else if (r_state == S_SCAN && !w_complete && !w_read && w_tmo_hit)
            r_timeout <= 1'b1;

         // The slot was free when the read was issued, so capture cannot
         // collide with a word still waiting for the consumer.
         if (r_state == S_DRAIN) begin
            r_move_data  <= col_data[r_sel*DW +: DW];
            r_move_valid <= 1'b1;
            r_rr_ptr     <= r_sel;
         end else if (w_xfer) begin
            r_move_valid <= 1'b0;
         end

         if (w_start_ok)
            r_move_count <= '0;
         else if (w_xfer && r_move_count != '1)
            r_move_count <= r_move_count + 1'b1;
      end
   end

   assign move_data  = r_move_data;
   assign move_valid = r_move_valid;
   assign timeout    = r_timeout;
   assign move_count = r_move_count;

endmodule

// File: tb/tb_board_move_collector.sv
// -----------------------------------------------------------------------------
// tb_board_move_collector
//
// Randomised scoreboard bench. Each pass loads per-column word queues; the
// expected output order is derived from the round-robin rule (columns drained
// whole, starting at the last column served) and pushed into exp_q. A monitor
// pops exp_q on every accepted transfer and also watches the read-enable and
// hold-while-stalled rules every cycle.
// -----------------------------------------------------------------------------
module tb_board_move_collector;

   localparam int NCOL   = 8;
   localparam int DW     = 160;
   localparam int CNTW   = 8;
   localparam int TMO    = 16;
   localparam int MAXCNT = (1 << CNTW) - 1;

   typedef logic [DW-1:0] word_t;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic                 col_reset;
   logic [NCOL-1:0]      col_done;
   logic [NCOL-1:0]      col_empty;
   logic [NCOL*DW-1:0]   col_data;
   logic [NCOL-1:0]      col_rden;
   word_t                move_data;
   logic                 move_valid;
   logic                 move_ready;
   logic                 busy;
   logic                 all_done;
   logic                 timeout;
   logic [CNTW-1:0]      move_count;

   board_move_collector #(
      .NCOL    (NCOL),
      .DW      (DW),
      .CNTW    (CNTW),
      .TMO_CYC (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .col_reset  (col_reset),
      .col_done   (col_done),
      .col_empty  (col_empty),
      .col_data   (col_data),
      .col_rden   (col_rden),
      .move_data  (move_data),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .busy       (busy),
      .all_done   (all_done),
      .timeout    (timeout),
      .move_count (move_count)
   );

   int              n_checks   = 0;
   int              n_errors   = 0;
   int              n_xfers    = 0;
   word_t           exp_q[$];
   word_t           col_q   [NCOL][$];
   word_t           stage_q [NCOL][$];
   logic [NCOL-1:0] stage_done = '0;
   int              load_seq   = 0;
   int              seen_seq   = 0;
   logic [NCOL-1:0] rden_s     = '0;
   int              ready_mode = 1;   // 0 random, 1 high, 2 low
   int              zero_run   = 0;
   int              rr_model   = 0;
   logic            prev_stall = 1'b0;
   logic            prev_rden  = 1'b0;
   word_t           prev_data  = '0;
   int              cnts [NCOL];

   task automatic check(input string name, input word_t act, input word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word_t rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Column FIFO model: a read enable seen in cycle t pops the word, which
   // then sits on col_data (and empty updates) during cycle t+1.
   initial begin
      col_done  = '0;
      col_empty = '1;
      col_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         if (load_seq != seen_seq) begin
            seen_seq = load_seq;
            for (int i = 0; i < NCOL; i++) col_q[i] = stage_q[i];
            col_done = stage_done;
         end else begin
            for (int i = 0; i < NCOL; i++)
               if (rden_s[i] && col_q[i].size() > 0)
                  col_data[i*DW +: DW] = col_q[i].pop_front();
         end
         for (int i = 0; i < NCOL; i++) col_empty[i] = (col_q[i].size() == 0);
      end
   end

   // Consumer: random backpressure with bounded stall runs.
   initial begin
      move_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 1)      move_ready = 1'b1;
         else if (ready_mode == 2) move_ready = 1'b0;
         else if (zero_run >= 5 || $urandom_range(0, 3) != 0) begin
            move_ready = 1'b1;
            zero_run   = 0;
         end else begin
            move_ready = 1'b0;
            zero_run++;
         end
      end
   end

   // Monitor: scoreboard pop on transfer plus per-cycle protocol rules.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (col_rden != '0) begin
               check("rden_onehot", word_t'($onehot(col_rden)), word_t'(1));
               check("rden_eligible", word_t'(col_rden & ~(col_done & ~col_empty)), '0);
               check("rden_back_to_back", word_t'(prev_rden), '0);
               check("rden_slot_busy", word_t'(move_valid & ~move_ready), '0);
            end
            if (prev_stall) begin
               check("hold_valid", word_t'(move_valid), word_t'(1));
               check("hold_data", move_data, prev_data);
            end
            if (move_valid && move_ready) begin
               n_xfers++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_move: got %h expected no transfer", move_data);
               end else begin
                  check("move_data", move_data, exp_q.pop_front());
               end
            end
         end
         prev_stall = !reset && move_valid && !move_ready;
         prev_rden  = !reset && (col_rden != '0);
         prev_data  = move_data;
         rden_s     = col_rden;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col_reset"},  word_t'(col_reset),  '0);
      check({tag, "_col_rden"},   word_t'(col_rden),   '0);
      check({tag, "_move_valid"}, word_t'(move_valid), '0);
      check({tag, "_move_data"},  move_data,           '0);
      check({tag, "_busy"},       word_t'(busy),       '0);
      check({tag, "_all_done"},   word_t'(all_done),   '0);
      check({tag, "_timeout"},    word_t'(timeout),    '0);
      check({tag, "_move_count"}, word_t'(move_count), '0);
   endtask

   task automatic load_columns(input int cn [NCOL], input logic [NCOL-1:0] dmask);
      @(posedge clk);
      #1;
      for (int i = 0; i < NCOL; i++) begin
         stage_q[i].delete();
         repeat (cn[i]) stage_q[i].push_back(rand_word());
      end
      stage_done = dmask;
      load_seq++;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // One full pass. Expected order: starting at the last column served, each
   // done column is emptied completely before moving to the next one.
   task automatic run_pass(input int cn [NCOL], input logic [NCOL-1:0] dmask,
                           input bit exp_tmo, input int stall);
      int total, last, xfers0, cyc, scan_cyc, c, exp_cnt;
      total = 0;
      last  = -1;
      load_columns(cn, dmask);
      for (int k = 0; k < NCOL; k++) begin
         c = (rr_model + k) % NCOL;
         if (dmask[c] && cn[c] > 0) begin
            foreach (stage_q[c][j]) exp_q.push_back(stage_q[c][j]);
            total += cn[c];
            last   = c;
         end
      end
      if (last >= 0) rr_model = last;
      exp_cnt = (total > MAXCNT) ? MAXCNT : total;
      xfers0  = n_xfers;

      pulse_start();
      @(negedge clk);
      check("rst_col_reset",  word_t'(col_reset),  word_t'(1));
      check("rst_busy",       word_t'(busy),       word_t'(1));
      check("rst_move_count", word_t'(move_count), '0);
      check("rst_timeout",    word_t'(timeout),    '0);
      @(negedge clk);
      check("col_reset_width", word_t'(col_reset), '0);
      check("scan_busy",       word_t'(busy),      word_t'(1));
      scan_cyc = 1;

      if (stall > 0) begin
         cyc = 0;
         while (!move_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
         end
         check("stall_valid_seen", word_t'(move_valid), word_t'(1));
         repeat (stall) @(negedge clk);
         check("stall_valid_held", word_t'(move_valid), word_t'(1));
         check("stall_first_word", move_data, (exp_q.size() > 0) ? exp_q[0] : '0);
         ready_mode = 1;
      end

      cyc = 0;
      while (!all_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (busy) scan_cyc++;
      end
      check("pass_completes", word_t'(all_done), word_t'(1));
      if (exp_tmo) check("timeout_scan_cycles", word_t'(scan_cyc), word_t'(TMO));
      check("timeout_flag", word_t'(timeout), word_t'(exp_tmo));
      check("move_count", word_t'(move_count), word_t'(exp_cnt));
      check("transfer_total", word_t'(n_xfers - xfers0), word_t'(total));
      check("scoreboard_drained", word_t'(exp_q.size()), '0);
      exp_q.delete();
   endtask

   // Reset lands in the capture cycle: the pass is abandoned with no output.
   task automatic abort_pass();
      int cyc;
      logic seen_valid;
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[4] = 1;
      load_columns(cnts, '1);
      pulse_start();
      cyc = 0;
      while (col_rden == '0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_rden_seen", word_t'(col_rden[4]), word_t'(1));
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
      seen_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen_valid = seen_valid | move_valid;
      end
      check("abort_no_valid", word_t'(seen_valid), '0);
      rr_model = 0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Single column, two words, consumer always ready.
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[3]    = 2;
      ready_mode = 1;
      run_pass(cnts, '1, 1'b0, 0);

      // Serve column 2 last so the following pass starts its search there.
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[2] = 1;
      run_pass(cnts, '1, 1'b0, 0);

      // Columns 0 and 5 from rr_ptr=2: column 5 first, then wrap to 0.
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[0] = 1;
      cnts[5] = 1;
      run_pass(cnts, '1, 1'b0, 0);

      // Consumer stalls for 10 cycles with three words pending.
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[1]    = 3;
      ready_mode = 2;
      run_pass(cnts, '1, 1'b0, 10);

      // Random word counts with random backpressure.
      repeat (6) begin
         for (int i = 0; i < NCOL; i++) cnts[i] = int'($urandom_range(0, 4));
         ready_mode = 0;
         run_pass(cnts, '1, 1'b0, 0);
      end

      // More moves than the counter can hold.
      for (int i = 0; i < NCOL; i++) cnts[i] = 34;
      ready_mode = 1;
      run_pass(cnts, '1, 1'b0, 0);

      // Column 6 never finishes: timeout after TMO idle scan cycles.
      for (int i = 0; i < NCOL; i++) cnts[i] = 0;
      cnts[6] = 2;
      run_pass(cnts, ~(NCOL'(1) << 6), 1'b1, 0);

      abort_pass();

      // Recovery after the aborted pass.
      for (int i = 0; i < NCOL; i++) cnts[i] = int'($urandom_range(0, 3));
      ready_mode = 0;
      run_pass(cnts, '1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
